coin_acceptor: RTL and testbench

//  Front end of the coin vending machine. Conditions two raw coin-slot sensors (1-unit, 2-unit):
//  - synchronises and debounces each sensor;
//  - validates the pulse width of each coin;
//  - queues accepted coins;
//  - presents them one at a time as 1-cycle codes on coin[1:0] for the vending FSM, which samples every clk.

---
 rtl/coin_pkg.sv | 14 +
 rtl/coin_acceptor_if.sv | 17 +
 rtl/coin_debounce.sv | 57 +++++
 rtl/coin_acceptor.sv | 138 +++++++++++++
 tb/tb_coin_acceptor.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/coin_pkg.sv
// Shared coin codes and emit-state encoding for the coin acceptor and the vending FSM.
package coin_pkg;
    localparam int COIN_W = 2;

    localparam logic [COIN_W-1:0] COIN_NONE = 2'b00;
    localparam logic [COIN_W-1:0] COIN_ONE  = 2'b01;
    localparam logic [COIN_W-1:0] COIN_TWO  = 2'b10;

    typedef enum logic [1:0] {
        EMIT_IDLE = 2'd0,
        EMIT_CODE = 2'd1,
        EMIT_GAP  = 2'd2
    } emit_state_t;
endpackage

// File: rtl/coin_acceptor_if.sv
// Sensor inputs and coin-code outputs between the coin slot front end and its surroundings.
interface coin_acceptor_if #(parameter int FIFO_DEPTH = 4);
    import coin_pkg::*;

    logic                        sens_one;
    logic                        sens_two;
    logic                        accept_en;
    logic [COIN_W-1:0]           coin;
    logic                        reject;
    logic [1:0]                  jam;
    logic [$clog2(FIFO_DEPTH):0] fifo_cnt;

    modport master (output sens_one, sens_two, accept_en,
                    input  coin, reject, jam, fifo_cnt);
    modport slave  (input  sens_one, sens_two, accept_en,
                    output coin, reject, jam, fifo_cnt);
endinterface

// File: rtl/coin_debounce.sv
// One sensor channel: 2-flop synchroniser, debouncer and pulse-width counter with jam detect.
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MIN_PULSE       = 3,
    parameter int MAX_PULSE       = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic sens,
    output logic done,
    output logic width_ok,
    output logic jam
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int WW = $clog2(MAX_PULSE + 2);
    localparam logic [WW-1:0] W_SAT = WW'(MAX_PULSE + 1);

    logic          sync1, sync2, level, flip;
    logic [DW-1:0] db_cnt;
    logic [WW-1:0] width, width_inc;

    assign flip      = (sync2 != level) && (db_cnt == DW'(DEBOUNCE_CYCLES - 1));
    assign width_inc = (width == W_SAT) ? W_SAT : width + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            level    <= 1'b0;
            db_cnt   <= '0;
            width    <= '0;
            jam      <= 1'b0;
            done     <= 1'b0;
            width_ok <= 1'b0;
        end else begin
            sync1    <= sens;
            sync2    <= sync1;
            done     <= 1'b0;
            width_ok <= 1'b0;
            // any agreeing sample restarts the stability count
            if (sync2 == level || flip) db_cnt <= '0;
            else                        db_cnt <= db_cnt + 1'b1;
            if (flip) level <= sync2;
            if (level) begin
                if (flip) begin
                    width    <= '0;
                    jam      <= 1'b0;
                    done     <= !jam;
                    width_ok <= (width_inc >= WW'(MIN_PULSE));
                end else begin
                    width <= width_inc;
                    if (width_inc > WW'(MAX_PULSE)) jam <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor top: two sensor channels, pending arbiter, coin queue and one-code-at-a-time emitter.
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MIN_PULSE       = 3,
    parameter int MAX_PULSE       = 200,
    parameter int FIFO_DEPTH      = 4,
    parameter int GAP_CYCLES      = 1
) (
    input logic            clk,
    input logic            rst,
    coin_acceptor_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH) + 1;
    localparam int GW = $clog2(GAP_CYCLES + 2);

    logic [1:0] sens, done, width_ok, jam, pending, served, complete_ok, complete_rej;

    assign sens = {bus.sens_two, bus.sens_one};

    coin_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .MIN_PULSE      (MIN_PULSE),
        .MAX_PULSE      (MAX_PULSE)
    ) u_db [1:0] (
        .clk     (clk),
        .rst     (rst),
        .sens    (sens),
        .done    (done),
        .width_ok(width_ok),
        .jam     (jam)
    );

    assign complete_ok  = done & width_ok & {2{bus.accept_en}};
    assign complete_rej = done & ~(width_ok & {2{bus.accept_en}});

    logic              wr_req;
    logic [COIN_W-1:0] wr_code;

    always_comb begin
        wr_req  = 1'b0;
        wr_code = COIN_NONE;
        served  = 2'b00;
        if (pending[0]) begin
            wr_req  = 1'b1;
            wr_code = COIN_ONE;
            served  = 2'b01;
        end else if (pending[1]) begin
            wr_req  = 1'b1;
            wr_code = COIN_TWO;
            served  = 2'b10;
        end
    end

    logic [COIN_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr, count;
    logic              full, empty, pop, push, drop, ready;

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == PW'(FIFO_DEPTH));
    assign empty = (count == '0);
    // a pop in the same cycle frees the slot, so a write against a full queue still lands
    assign push  = wr_req && (!full || pop);
    assign drop  = wr_req && full && !pop;

    emit_state_t       state, state_nxt;
    logic [GW-1:0]     gap_cnt, gap_nxt;
    logic [COIN_W-1:0] code_q;

    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        ready     = 1'b0;
        unique case (state)
            EMIT_IDLE: ready = 1'b1;
            EMIT_CODE: begin
                gap_nxt = '0;
                if (GAP_CYCLES == 0) begin
                    ready     = 1'b1;
                    state_nxt = EMIT_IDLE;
                end else begin
                    state_nxt = EMIT_GAP;
                end
            end
            EMIT_GAP: begin
                gap_nxt = gap_cnt + 1'b1;
                if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                    ready     = 1'b1;
                    state_nxt = EMIT_IDLE;
                end
            end
            default: state_nxt = EMIT_IDLE;
        endcase
        pop = ready && !empty;
        if (pop) state_nxt = EMIT_CODE;
    end

    logic [1:0] rej_hold;
    logic [2:0] rej_total;

    assign rej_total = 3'(rej_hold) + 3'(complete_rej[0]) + 3'(complete_rej[1]) + 3'(drop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMIT_IDLE;
            gap_cnt    <= '0;
            code_q     <= COIN_NONE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pending    <= 2'b00;
            bus.reject <= 1'b0;
            rej_hold   <= '0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_nxt;
            pending <= (pending & ~served) | complete_ok;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                code_q <= mem[rd_ptr[PW-2:0]];
            end
            // one pulse per cycle; extra events in the same cycle spill into following cycles
            bus.reject <= (rej_total != '0);
            if (rej_total == '0)     rej_hold <= '0;
            else if (rej_total > 3'd4) rej_hold <= 2'd3;
            else                     rej_hold <= 2'(rej_total - 3'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-2:0]] <= wr_code;
    end

    assign bus.coin     = (state == EMIT_CODE) ? code_q : COIN_NONE;
    assign bus.jam      = jam;
    assign bus.fifo_cnt = count;
endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench: expected coin codes are queued at raw sensor fall and matched as codes appear.
module tb_coin_acceptor;
    import coin_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    coin_acceptor_if bus ();
    coin_acceptor_if sbus ();

    coin_acceptor dut (.clk(clk), .rst(rst), .bus(bus));
    coin_acceptor #(.GAP_CYCLES(150)) dut_slow (.clk(clk), .rst(rst), .bus(sbus));

    typedef struct {
        logic [1:0] code;
        int         due;
    } exp_t;

    exp_t fast_q[$], slow_q[$];
    exp_t fe, se;
    int   cyc = 0;
    int   n_vec = 0, n_err = 0;
    int   fast_rej = 0, slow_rej = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic goto(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.coin != COIN_NONE) begin
            if (fast_q.size() == 0) chk("fast_unexp", 32'(bus.coin), 32'(COIN_NONE));
            else begin
                fe = fast_q.pop_front();
                chk("fast_code", 32'(bus.coin), 32'(fe.code));
                if (fe.due >= 0) chk("fast_cycle", cyc, fe.due);
            end
        end
        if (!rst && sbus.coin != COIN_NONE) begin
            if (slow_q.size() == 0) chk("slow_unexp", 32'(sbus.coin), 32'(COIN_NONE));
            else begin
                se = slow_q.pop_front();
                chk("slow_code", 32'(sbus.coin), 32'(se.code));
                if (se.due >= 0) chk("slow_cycle", cyc, se.due);
            end
        end
        if (bus.reject)  fast_rej++;
        if (sbus.reject) slow_rej++;
    end

    initial begin
        int f, r, rej0, f0;
        rst = 1'b1;
        bus.sens_one  = 1'b0; bus.sens_two  = 1'b0; bus.accept_en  = 1'b1;
        sbus.sens_one = 1'b0; sbus.sens_two = 1'b0; sbus.accept_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_coin", 32'(bus.coin), 0);
        chk("rst_reject", 32'(bus.reject), 0);
        chk("rst_jam", 32'(bus.jam), 0);
        chk("rst_fifo_cnt", 32'(bus.fifo_cnt), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // single 1-unit coin
        rej0 = fast_rej;
        bus.sens_one = 1'b1;
        repeat (10) @(negedge clk);
        bus.sens_one = 1'b0;
        f = cyc;
        fast_q.push_back('{COIN_ONE, f + 9});
        goto(f + 15);
        chk("t1_reject", fast_rej - rej0, 0);
        chk("t1_jam", 32'(bus.jam), 0);

        // 2-cycle glitch must never debounce
        rej0 = fast_rej;
        bus.sens_two = 1'b1;
        repeat (2) @(negedge clk);
        bus.sens_two = 1'b0;
        repeat (15) @(negedge clk);
        chk("t2_reject", fast_rej - rej0, 0);
        chk("t2_fifo_cnt", 32'(bus.fifo_cnt), 0);

        // simultaneous coins: channel one first, one gap cycle, then channel two
        rej0 = fast_rej;
        bus.sens_one = 1'b1; bus.sens_two = 1'b1;
        repeat (10) @(negedge clk);
        bus.sens_one = 1'b0; bus.sens_two = 1'b0;
        f = cyc;
        fast_q.push_back('{COIN_ONE, f + 9});
        fast_q.push_back('{COIN_TWO, f + 11});
        goto(f + 20);
        chk("t3_reject", fast_rej - rej0, 0);

        // long 2-unit pulse jams the channel
        rej0 = fast_rej;
        bus.sens_two = 1'b1;
        r = cyc;
        goto(r + 206);
        chk("t5_jam_before", 32'(bus.jam), 0);
        goto(r + 207);
        chk("t5_jam_set", 32'(bus.jam), 2);
        goto(r + 250);
        bus.sens_two = 1'b0;
        f = cyc;
        goto(f + 5);
        chk("t5_jam_held", 32'(bus.jam), 2);
        goto(f + 6);
        chk("t5_jam_clear", 32'(bus.jam), 0);
        goto(f + 15);
        chk("t5_reject", fast_rej - rej0, 0);

        // accept disabled: coin rejected, none emitted
        rej0 = fast_rej;
        bus.accept_en = 1'b0;
        bus.sens_one  = 1'b1;
        repeat (10) @(negedge clk);
        bus.sens_one = 1'b0;
        repeat (15) @(negedge clk);
        chk("t6_reject", fast_rej - rej0, 1);
        bus.accept_en = 1'b1;

        // queue overflow on the slow instance, held off by a long gap after a 2-unit coin
        rej0 = slow_rej;
        sbus.sens_two = 1'b1;
        repeat (10) @(negedge clk);
        sbus.sens_two = 1'b0;
        f0 = cyc;
        slow_q.push_back('{COIN_TWO, f0 + 9});
        for (int k = 0; k < 6; k++) begin
            sbus.sens_one = 1'b1;
            repeat (8) @(negedge clk);
            sbus.sens_one = 1'b0;
            if (k < 4) slow_q.push_back('{COIN_ONE, -1});
            repeat (8) @(negedge clk);
        end
        goto(f0 + 110);
        chk("t4_fifo_full", 32'(sbus.fifo_cnt), 4);
        chk("t4_reject", slow_rej - rej0, 2);
        goto(f0 + 800);
        chk("t4_drained", slow_q.size(), 0);
        chk("t4_fifo_empty", 32'(sbus.fifo_cnt), 0);

        // reset in the middle of a coin discards it silently
        rej0 = fast_rej;
        bus.sens_one = 1'b1;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus.sens_one = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_rst_coin", 32'(bus.coin), 0);
        chk("t6_rst_reject", 32'(bus.reject), 0);
        chk("t6_rst_jam", 32'(bus.jam), 0);
        chk("t6_rst_fifo_cnt", 32'(bus.fifo_cnt), 0);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("t6_rst_noreject", fast_rej - rej0, 0);

        // next coin after reset is handled normally
        bus.sens_one = 1'b1;
        repeat (10) @(negedge clk);
        bus.sens_one = 1'b0;
        f = cyc;
        fast_q.push_back('{COIN_ONE, f + 9});
        goto(f + 15);
        chk("fast_drained", fast_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
